// File: rtl/pawc_sram_pkg.sv
// Shared types and helpers for the Wishbone-to-16-bit asynchronous SRAM bridge.
package pawc_sram_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_STRB,
      ST_HOLD,
      ST_ACK
   } state_e;

   localparam logic HALF_LO = 1'b0;
   localparam logic HALF_HI = 1'b1;

   function automatic int strb_cnt_w(input int wait_cycles);
      return $clog2(wait_cycles + 1);
   endfunction

endpackage

// File: rtl/pawc_wb_sram_if.sv
// Wishbone pipelined-mode bus bundle between the SoC RAM master and the SRAM bridge.
interface pawc_wb_sram_if;

   logic        i_wb_cyc;
   logic        i_wb_stb;
   logic        i_wb_we;
   logic [31:0] i_wb_addr;
   logic [31:0] i_wb_data;
   logic [3:0]  i_wb_sel;
   logic        o_wb_ack;
   logic        o_wb_stall;
   logic [31:0] o_wb_data;

   modport master (
      output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
      input  o_wb_ack, o_wb_stall, o_wb_data
   );

   modport slave (
      input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
      output o_wb_ack, o_wb_stall, o_wb_data
   );

endinterface

// File: rtl/pawc_wb_sram.sv
// Wishbone slave splitting each 32-bit access into two half-word async SRAM cycles.
// Optional one-word read buffer enabled by defining READ_BUF_EN.
module pawc_wb_sram
   import pawc_sram_pkg::*;
#(
   parameter int SRAM_ADDR_W = 18,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   resetn,
   pawc_wb_sram_if.slave          wb,
   output logic [SRAM_ADDR_W-1:0] o_sram_addr,
   output logic [15:0]            o_sram_dq_out,
   output logic                   o_sram_dq_oe,
   input  logic [15:0]            i_sram_dq_in,
   output logic                   o_sram_ce_n,
   output logic                   o_sram_oe_n,
   output logic                   o_sram_we_n,
   output logic                   o_sram_ub_n,
   output logic                   o_sram_lb_n
);

   localparam int CNT_W = strb_cnt_w(WAIT_CYCLES);
   localparam int WA_W  = SRAM_ADDR_W - 1;

   state_e                 state_q, state_d;
   logic                   half_q, half_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   abort_q, abort_d;
   logic                   we_q, we_d;
   logic [3:0]             sel_q, sel_d;
   logic [31:0]            wdata_q, wdata_d;
   logic [WA_W-1:0]        waddr_q, waddr_d;

   logic                   ack_q, ack_d;
   logic                   stall_q, stall_d;
   logic [31:0]            rdata_q, rdata_d;
   logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
   logic [15:0]            dq_out_q, dq_out_d;
   logic                   dq_oe_q, dq_oe_d;
   logic                   ce_n_q, ce_n_d;
   logic                   oe_n_q, oe_n_d;
   logic                   we_n_q, we_n_d;
   logic                   ub_n_q, ub_n_d;
   logic                   lb_n_q, lb_n_d;

   logic                   accept;
   logic                   unused_addr_bits;

`ifdef READ_BUF_EN
   logic                   buf_vld_q, buf_vld_d;
   logic [WA_W-1:0]        buf_waddr_q, buf_waddr_d;
   logic [31:0]            buf_data_q, buf_data_d;
   logic                   buf_match;
`endif

   assign accept           = (state_q == ST_IDLE) && wb.i_wb_cyc && wb.i_wb_stb && !stall_q;
   assign unused_addr_bits = ^{wb.i_wb_addr[31:SRAM_ADDR_W+1], wb.i_wb_addr[1:0]};

`ifdef READ_BUF_EN
   assign buf_match = buf_vld_q && (buf_waddr_q == wb.i_wb_addr[SRAM_ADDR_W:2]);
`endif

   always_comb begin
      state_d = state_q;
      half_d  = half_q;
      cnt_d   = cnt_q;
      abort_d = abort_q;
      we_d    = we_q;
      sel_d   = sel_q;
      wdata_d = wdata_q;
      waddr_d = waddr_q;
      rdata_d = rdata_q;
`ifdef READ_BUF_EN
      buf_vld_d   = buf_vld_q;
      buf_waddr_d = buf_waddr_q;
      buf_data_d  = buf_data_q;
`endif

      case (state_q)
         ST_IDLE: begin
            abort_d = 1'b0;
            if (accept) begin
               we_d    = wb.i_wb_we;
               sel_d   = wb.i_wb_sel;
               wdata_d = wb.i_wb_data;
               waddr_d = wb.i_wb_addr[SRAM_ADDR_W:2];
               if (wb.i_wb_we) begin
`ifdef READ_BUF_EN
                  if (buf_match) buf_vld_d = 1'b0;
`endif
                  // Halves with no selected bytes are never touched on the SRAM.
                  if (wb.i_wb_sel[1:0] != 2'b00) begin
                     state_d = ST_ADDR;
                     half_d  = HALF_LO;
                  end else if (wb.i_wb_sel[3:2] != 2'b00) begin
                     state_d = ST_ADDR;
                     half_d  = HALF_HI;
                  end else begin
                     state_d = ST_ACK;
                  end
`ifdef READ_BUF_EN
               end else if (buf_match) begin
                  state_d = ST_ACK;
                  rdata_d = buf_data_q;
`endif
               end else begin
                  state_d = ST_ADDR;
                  half_d  = HALF_LO;
               end
            end
         end
         ST_ADDR: begin
            state_d = ST_STRB;
            cnt_d   = CNT_W'(WAIT_CYCLES);
         end
         ST_STRB: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_HOLD;
               if (!we_q) begin
                  if (half_q == HALF_HI) rdata_d[31:16] = i_sram_dq_in;
                  else                   rdata_d[15:0]  = i_sram_dq_in;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_HOLD: begin
            if (abort_q || !wb.i_wb_cyc) begin
               state_d = ST_IDLE;
`ifdef READ_BUF_EN
               buf_vld_d = 1'b0;
`endif
            end else if ((half_q == HALF_LO) && (!we_q || (sel_q[3:2] != 2'b00))) begin
               state_d = ST_ADDR;
               half_d  = HALF_HI;
            end else begin
               state_d = ST_ACK;
`ifdef READ_BUF_EN
               // The high half was captured at the end of its strobe, so rdata_q is complete.
               if (!we_q) begin
                  buf_vld_d   = 1'b1;
                  buf_waddr_d = waddr_q;
                  buf_data_d  = rdata_q;
               end
`endif
            end
         end
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if ((state_q != ST_IDLE) && !wb.i_wb_cyc) abort_d = 1'b1;
   end

   // Output registers are loaded for the state being entered, so pins change with the state.
   always_comb begin
      ack_d       = (state_d == ST_ACK);
      stall_d     = (state_d != ST_IDLE);
      sram_addr_d = sram_addr_q;
      dq_out_d    = dq_out_q;
      dq_oe_d     = dq_oe_q;
      ce_n_d      = ce_n_q;
      oe_n_d      = oe_n_q;
      we_n_d      = we_n_q;
      ub_n_d      = ub_n_q;
      lb_n_d      = lb_n_q;

      case (state_d)
         ST_ADDR: begin
            sram_addr_d = {waddr_d, half_d};
            ce_n_d      = 1'b0;
            oe_n_d      = 1'b1;
            we_n_d      = 1'b1;
            if (we_d) begin
               ub_n_d   = !(half_d ? sel_d[3] : sel_d[1]);
               lb_n_d   = !(half_d ? sel_d[2] : sel_d[0]);
               dq_out_d = half_d ? wdata_d[31:16] : wdata_d[15:0];
               dq_oe_d  = 1'b1;
            end else begin
               ub_n_d   = 1'b0;
               lb_n_d   = 1'b0;
               dq_oe_d  = 1'b0;
            end
         end
         ST_STRB: begin
            we_n_d = !we_q;
            oe_n_d = we_q;
         end
         ST_HOLD: begin
            we_n_d = 1'b1;
            oe_n_d = 1'b1;
         end
         default: begin
            ce_n_d  = 1'b1;
            oe_n_d  = 1'b1;
            we_n_d  = 1'b1;
            ub_n_d  = 1'b1;
            lb_n_d  = 1'b1;
            dq_oe_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         half_q      <= HALF_LO;
         cnt_q       <= '0;
         abort_q     <= 1'b0;
         we_q        <= 1'b0;
         ack_q       <= 1'b0;
         stall_q     <= 1'b0;
         rdata_q     <= '0;
         sram_addr_q <= '0;
         dq_out_q    <= '0;
         dq_oe_q     <= 1'b0;
         ce_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
         ub_n_q      <= 1'b1;
         lb_n_q      <= 1'b1;
`ifdef READ_BUF_EN
         buf_vld_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         half_q      <= half_d;
         cnt_q       <= cnt_d;
         abort_q     <= abort_d;
         we_q        <= we_d;
         ack_q       <= ack_d;
         stall_q     <= stall_d;
         rdata_q     <= rdata_d;
         sram_addr_q <= sram_addr_d;
         dq_out_q    <= dq_out_d;
         dq_oe_q     <= dq_oe_d;
         ce_n_q      <= ce_n_d;
         oe_n_q      <= oe_n_d;
         we_n_q      <= we_n_d;
         ub_n_q      <= ub_n_d;
         lb_n_q      <= lb_n_d;
`ifdef READ_BUF_EN
         buf_vld_q   <= buf_vld_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
`ifdef READ_BUF_EN
      buf_waddr_q <= buf_waddr_d;
      buf_data_q  <= buf_data_d;
`endif
   end

   assign wb.o_wb_ack   = ack_q;
   assign wb.o_wb_stall = stall_q;
   assign wb.o_wb_data  = rdata_q;
   assign o_sram_addr   = sram_addr_q;
   assign o_sram_dq_out = dq_out_q;
   assign o_sram_dq_oe  = dq_oe_q;
   assign o_sram_ce_n   = ce_n_q;
   assign o_sram_oe_n   = oe_n_q;
   assign o_sram_we_n   = we_n_q;
   assign o_sram_ub_n   = ub_n_q;
   assign o_sram_lb_n   = lb_n_q;

endmodule

// File: tb/tb_pawc_wb_sram.sv
// Bench for pawc_wb_sram: behavioural SRAM, word-level reference memory, directed plus random accesses.
module tb_pawc_wb_sram;

   localparam int AW = 18;
   localparam int WC = 2;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic [AW-1:0] sram_addr;
   logic [15:0]   dq_out, dq_in;
   logic          dq_oe, ce_n, oe_n, we_n, ub_n, lb_n;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pawc_wb_sram_if wb();

   pawc_wb_sram #(.SRAM_ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .wb            (wb),
      .o_sram_addr   (sram_addr),
      .o_sram_dq_out (dq_out),
      .o_sram_dq_oe  (dq_oe),
      .i_sram_dq_in  (dq_in),
      .o_sram_ce_n   (ce_n),
      .o_sram_oe_n   (oe_n),
      .o_sram_we_n   (we_n),
      .o_sram_ub_n   (ub_n),
      .o_sram_lb_n   (lb_n)
   );

   // Asynchronous SRAM: reads are combinational, writes land while ce/we are low and the pads drive.
   logic [15:0] mem [0:(1<<AW)-1];
   assign dq_in = (!ce_n && !oe_n) ? mem[sram_addr] : 16'h0000;

   always @(posedge clk) begin
      if (!ce_n && !we_n && dq_oe) begin
         if (!lb_n) mem[sram_addr][7:0]  <= dq_out[7:0];
         if (!ub_n) mem[sram_addr][15:8] <= dq_out[15:8];
      end
   end

   // Reference: 32-bit word memory and read-buffer bookkeeping.
   logic [31:0] ref_mem [0:15];
   bit          buf_vld = 1'b0;
   int          buf_w   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] sel, input int drop_at,
                          output int lat, output int ce_cnt, output int we_cnt,
                          output logic [3:0] lanes, output logic [31:0] rdata,
                          output bit hi_seen, output int stall_low_at);
      @(negedge clk);
      wb.i_wb_cyc  = 1'b1;
      wb.i_wb_stb  = 1'b1;
      wb.i_wb_we   = we;
      wb.i_wb_addr = addr;
      wb.i_wb_data = data;
      wb.i_wb_sel  = sel;
      @(posedge clk);
      lat = -1; ce_cnt = 0; we_cnt = 0; lanes = 4'b0000; rdata = 32'h0;
      hi_seen = 1'b0; stall_low_at = -1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (k == 1) wb.i_wb_stb = 1'b0;
         if (k == drop_at) wb.i_wb_cyc = 1'b0;
         if (!ce_n) ce_cnt++;
         if (!ce_n && sram_addr[0]) hi_seen = 1'b1;
         if (!we_n) begin
            we_cnt++;
            if (!lb_n) lanes[{sram_addr[0], 1'b0}] = 1'b1;
            if (!ub_n) lanes[{sram_addr[0], 1'b1}] = 1'b1;
         end
         if (stall_low_at < 0 && !wb.o_wb_stall) stall_low_at = k;
         if (wb.o_wb_ack) begin
            lat   = k;
            rdata = wb.o_wb_data;
            break;
         end
         if (drop_at > 0 && k >= drop_at + 12) break;
      end
      wb.i_wb_cyc = 1'b0;
   endtask

   // One transaction checked against latency/strobe counts and data derived from the word model.
   task automatic txn_check(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] sel);
      int          w, nh, exp_lat, lat, ce_cnt, we_cnt, stall_low_at;
      bit          hit, hi_seen;
      logic [3:0]  lanes;
      logic [31:0] rdata;
      w   = int'(addr[5:2]);
      nh  = we ? (int'(sel[1:0] != 2'b00) + int'(sel[3:2] != 2'b00)) : 2;
      hit = 1'b0;
`ifdef READ_BUF_EN
      hit = !we && buf_vld && (buf_w == w);
`endif
      if (hit) nh = 0;
      exp_lat = (nh == 0) ? 1 : nh * (WC + 2) + 1;
      run_txn(we, addr, data, sel, 0, lat, ce_cnt, we_cnt, lanes, rdata, hi_seen, stall_low_at);
      check({tag, ".lat"}, lat, exp_lat);
      check({tag, ".ce_cycles"}, ce_cnt, nh * (WC + 2));
      check({tag, ".we_cycles"}, we_cnt, we ? nh * WC : 0);
      if (we) begin
         check({tag, ".lanes"}, {28'h0, lanes}, {28'h0, sel});
         for (int b = 0; b < 4; b++)
            if (sel[b]) ref_mem[w][b*8 +: 8] = data[b*8 +: 8];
         if (buf_w == w) buf_vld = 1'b0;
      end else begin
         check({tag, ".rdata"}, rdata, ref_mem[w]);
         buf_vld = 1'b1;
         buf_w   = w;
      end
   endtask

   initial begin
      int          lat, ce_cnt, we_cnt, stall_low_at, ack_cnt;
      bit          hi_seen;
      logic [3:0]  lanes;
      logic [31:0] rdata, addr;
      logic        we;

      wb.i_wb_cyc = 1'b0; wb.i_wb_stb = 1'b0; wb.i_wb_we = 1'b0;
      wb.i_wb_addr = 32'h0; wb.i_wb_data = 32'h0; wb.i_wb_sel = 4'h0;
      for (int i = 0; i < 16; i++) begin
         ref_mem[i]   = $urandom;
         mem[2*i]     = ref_mem[i][15:0];
         mem[2*i + 1] = ref_mem[i][31:16];
      end

      repeat (3) @(posedge clk);
      #1;
      check("rst.ctrl", {24'h0, wb.o_wb_ack, wb.o_wb_stall, ce_n, oe_n, we_n, ub_n, lb_n, dq_oe},
            32'b0011_1110);
      check("rst.wb_data", wb.o_wb_data, 32'h0);
      check("rst.sram_addr", {14'h0, sram_addr}, 32'h0);
      check("rst.dq_out", {16'h0, dq_out}, 32'h0);
      @(negedge clk) resetn = 1'b1;

      // Reset asserted in the middle of a write strobe.
      @(negedge clk);
      wb.i_wb_cyc = 1'b1; wb.i_wb_stb = 1'b1; wb.i_wb_we = 1'b1;
      wb.i_wb_addr = 32'h100; wb.i_wb_data = 32'h1234_5678; wb.i_wb_sel = 4'hF;
      @(posedge clk);
      @(negedge clk) wb.i_wb_stb = 1'b0;
      @(negedge clk);
      check("rstmid.we_low_before", {31'h0, we_n}, 32'h0);
      #2 resetn = 1'b0;
      #1;
      check("rstmid.strobes", {28'h0, we_n, ce_n, dq_oe, oe_n}, 32'b1101);
      wb.i_wb_cyc = 1'b0;
      buf_vld = 1'b0;
      @(negedge clk) resetn = 1'b1;
      ack_cnt = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (wb.o_wb_ack) ack_cnt++;
      end
      check("rstmid.no_ack", ack_cnt, 0);

      // Directed scenarios on byte address 0x10.
      txn_check("wr_full", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
      check("wr_full.mem_lo", {16'h0, mem[8]}, 32'h0000_BEEF);
      check("wr_full.mem_hi", {16'h0, mem[9]}, 32'h0000_DEAD);
      txn_check("rd_back", 1'b0, 32'h10, 32'h0, 4'hF);
      txn_check("rd_again", 1'b0, 32'h10, 32'h0, 4'h0);
      txn_check("wr_byte", 1'b1, 32'h10, 32'h0000_00AB, 4'h1);
      txn_check("rd_byte", 1'b0, 32'h10, 32'h0, 4'hF);
      txn_check("wr_sel0", 1'b1, 32'h14, 32'hFFFF_FFFF, 4'h0);
      txn_check("wr_hi_only", 1'b1, 32'h18, 32'hCAFE_0000, 4'hC);

      // Cycle dropped during the low-half strobe of a read.
      run_txn(1'b0, 32'h20, 32'h0, 4'hF, 2, lat, ce_cnt, we_cnt, lanes, rdata, hi_seen, stall_low_at);
      check("drop.no_ack", lat, -1);
      check("drop.no_hi_half", {31'h0, hi_seen}, 32'h0);
      check("drop.ce_cycles", ce_cnt, WC + 2);
      check("drop.stall_fall", stall_low_at, WC + 3);
      buf_vld = 1'b0;

      // Random traffic over 16 words with junk in the ignored address bits.
      for (int n = 0; n < 40; n++) begin
         we   = 1'($urandom_range(0, 1));
         addr = {13'($urandom), 13'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
         txn_check($sformatf("rnd%0d", n), we, addr, $urandom, 4'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pawc_wb_sram.md
# pawc_wb_sram

Wishbone pipelined-mode slave that serves the external RAM window of the PicoRV32 SoC by driving a 16-bit asynchronous SRAM. It connects directly to the RAM-side Wishbone master port of the top level, whose addresses are already offset-corrected to zero-based byte addresses. Each 32-bit access is split into two registered half-word SRAM cycles with programmable strobe width. The block handles byte-lane writes, always returns full-word reads, and holds the bus stalled while a transfer is in progress.

## Interface
- SRAM_ADDR_W, 18: SRAM half-word address width.
- WAIT_CYCLES, 2: width of the OE_n/WE_n strobe in clocks. Must be at least 1.
- clk  in  1  system clock.
- resetn  in  1  reset. One clock; reset is asynchronous and active-low.
- i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  Wishbone cycle, strobe and write enable.
- i_wb_addr  in  32  byte address. Bits [SRAM_ADDR_W:2] are used; all others are ignored.
- i_wb_data  in  32  write data.
- i_wb_sel  in  4  byte-lane selects.
- o_wb_ack  out  1  single-cycle acknowledge.
- o_wb_stall  out  1  busy indicator.
- o_wb_data  out  32  read data.
- o_sram_addr  out  SRAM_ADDR_W  half-word address, equal to {i_wb_addr[SRAM_ADDR_W:2], half}. half is 0 for bits [15:0] and 1 for bits [31:16].
- o_sram_dq_out  out  16  data driven onto the SRAM bus.
- o_sram_dq_oe  out  1  enables the pad tristate driver.
- i_sram_dq_in  in  16  data read from the SRAM bus.
- o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_ub_n, o_sram_lb_n  out  1 each  SRAM control strobes, active-low.

## Operation
- **Registered outputs.** Every output is a register.
- **Reset state.**
  - o_wb_ack=0, o_wb_stall=0, o_wb_data=0.
  - All SRAM _n strobes =1.
  - o_sram_dq_oe=0, o_sram_addr=0, o_sram_dq_out=0.
  - FSM in IDLE.
- **Request acceptance.** A request is accepted when cyc, stb and !stall are all high. On acceptance the block latches addr, data, we and sel.
- **Stall.** o_wb_stall=1 in every state except IDLE. It rises in the cycle after acceptance.
- **FSM states.** IDLE, ADDR, STRB, HOLD, ACK. A half register selects the current half-word.
- **ADDR (1 cycle).**
  - Drive the address, ce_n=0, ub_n/lb_n.
  - For writes: dq_out and dq_oe=1.
- **STRB (WAIT_CYCLES cycles).**
  - Writes drive we_n=0; reads drive oe_n=0.
  - Reads capture i_sram_dq_in into the selected half of o_wb_data on the last STRB cycle.
- **HOLD (1 cycle).**
  - we_n and oe_n return to 1; address and data are held; ce_n=0.
  - Then either go to ADDR for the high half, or go to ACK.
- **ACK.** o_wb_ack=1 for exactly one cycle, then return to IDLE. ce_n returns to 1 in ACK.
- **Byte lanes on writes.**
  - ub_n = !sel[1] or !sel[3] for the current half; lb_n = !sel[0] or !sel[2] likewise.
  - A half whose two sel bits are both 0 is skipped.
  - sel=0000 goes directly IDLE→ACK with no SRAM activity.
- **Reads.** Always perform both halves with ub_n=lb_n=0, regardless of sel.
- **Cycle drop.** If cyc falls mid-transfer, the current half completes through HOLD. The FSM then returns to IDLE without an ack and the remaining half is not performed.
- **Reset mid-transfer.** All strobes go inactive immediately, asynchronously. No ack is issued.

## Timing
- **Read latency.** Acceptance edge = cycle 0. o_wb_ack is high in cycle 2·(WAIT_CYCLES+2)+1, which is cycle 9 at the default.
- **Single-half write.** Ack is high in cycle WAIT_CYCLES+3.
- **sel=0000 write.** Ack is high in cycle 1.
- **Back-to-back requests.** The next request can be accepted in the cycle after ACK, when stall is low.
- **Read data.** o_wb_data is valid in the ack cycle and is held until the next read captures.

## Configuration
- **READ_BUF_EN defined.** Adds a one-word read buffer holding the last read word address, its data, and a valid bit.
  - A read whose address matches while valid=1 goes IDLE→ACK, acknowledging in cycle 1 with the buffered data and no SRAM activity.
  - A write to the matching word clears valid.
  - Reset clears valid.
  - A cycle-drop abort leaves valid=0.
- **READ_BUF_EN undefined.** Every read accesses the SRAM.

## Structure
- **Package pawc_sram_pkg holds:**
  - the FSM state enum;
  - the half-select localparams;
  - a function that computes the strobe counter width, $clog2(WAIT_CYCLES+1).
- **Sub-modules.** None; the block is a single module. The strobe timer is a down-counter internal to the FSM.

## Test plan
All scenarios use WAIT_CYCLES=2.
- **Reset values.** Assert resetn=0 mid-STRB of a write → we_n=1, ce_n=1, dq_oe=0 immediately; no ack after release.
- **Full-word write.** Write 0xDEADBEEF to byte address 0x10, sel=1111 → SRAM half address 0x8 gets 0xBEEF, then 0x9 gets 0xDEAD. we_n is low for exactly 2 cycles per half; ack at cycle 9.
- **Byte write.** Write 0x000000AB to address 0x10 with sel=0001 → only the low half is accessed, with lb_n=0 and ub_n=1; ack at cycle 5.
- **Readback.** Read address 0x10 with the SRAM model returning 0xBEEF then 0xDEAD → o_wb_data=0xDEADBEEF at the ack in cycle 9.
- **Cycle drop.** Drop cyc in the low-half STRB of a read → the low half finishes, there is no high-half access and no ack, and stall falls.
- **READ_BUF_EN.** Read 0x10 twice → the second read acks at cycle 1 with no ce_n activity. Write 0x10, then read 0x10 → the read takes the full 9 cycles.
